// File: rtl/alu_control_unit_pkg.sv
// alu_control_unit_pkg
// Shared constants for the decode/issue stage: RV32I opcodes, funct3/funct7
// values, ALU control words, operand-A select encodings, the immediate-format
// enum and the packed per-entry control record carried through the
// output/skid registers.
package alu_control_unit_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SGE  = 4'b1010;
  localparam logic [3:0] ALU_SGEU = 4'b1011;
  localparam logic [3:0] ALU_JMP  = 4'b1001;
  localparam logic [3:0] ALU_ERR  = 4'b1111;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [3:0] alu_control;
    logic [1:0] src_a;
    logic       src_b_imm;
    logic       branch;
    logic       branch_negate;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // Shift-immediates carry only the shamt so the ALU sees a plain shift amount.
  function automatic imm_fmt_e imm_fmt(input logic [31:0] instr);
    imm_fmt_e f;
    f = IMM_NONE;
    case (instr[6:0])
      OPC_OP_IMM: f = (instr[14:12] == F3_SLL || instr[14:12] == F3_SR) ? IMM_SHAMT : IMM_I;
      OPC_LOAD,
      OPC_JALR:   f = IMM_I;
      OPC_STORE:  f = IMM_S;
      OPC_BRANCH: f = IMM_B;
      OPC_LUI,
      OPC_AUIPC:  f = IMM_U;
      OPC_JAL:    f = IMM_J;
      default:    f = IMM_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_control_unit_imm_gen.sv
// alu_control_unit_imm_gen
// Combinational immediate generator: selects the RV32I immediate format from
// the opcode and sign-extends it to WIDTH.
// Ports:
//   instr  in   raw 32-bit instruction
//   imm    out  sign-extended immediate (0 for formats without one)
module alu_control_unit_imm_gen
  import alu_control_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  output logic [WIDTH-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_fmt(instr))
      IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_SHAMT: imm32 = {27'd0, instr[24:20]};
      IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm32 = {instr[31:12], 12'd0};
      IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:   imm32 = '0;
    endcase
  end

  assign imm = WIDTH'($signed(imm32));

endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit
// Decode/issue stage: registers the RV32I decode (ALU control word
// {inverse, func3}, operand selects, immediate, branch/jump flags) behind a
// valid/ready handshake. A second (skid) register lets in_ready depend only on
// registered state. flush empties both registers and drops the incoming entry.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        upstream handshake; in_instr, in_pc payload
//   flush                    kill held and incoming entries
//   out_valid/out_ready      downstream handshake
//   out_alu_control..out_pc  decoded entry
//   illegal_count            saturating count of accepted illegal instructions
module alu_control_unit
  import alu_control_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [WIDTH-1:0]     in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_alu_control,
  output logic [1:0]           out_src_a,
  output logic                 out_src_b_imm,
  output logic [WIDTH-1:0]     out_imm,
  output logic                 out_branch,
  output logic                 out_branch_negate,
  output logic                 out_jump,
  output logic                 out_illegal,
  output logic [WIDTH-1:0]     out_pc,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [WIDTH-1:0] imm_raw;
  logic [WIDTH-1:0] dec_imm;
  ctrl_t            dec;
  logic             legal;

  ctrl_t            out_q, skid_q;
  logic [WIDTH-1:0] out_imm_q, skid_imm_q, out_pc_q, skid_pc_q;
  logic             out_valid_q, skid_valid_q;
  logic             accept, load_out;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  alu_control_unit_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .instr (in_instr),
    .imm   (imm_raw)
  );

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE)
          dec.alu_control = {1'b0, f3};
        else if (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))
          dec.alu_control = {1'b1, f3};
        else
          legal = 1'b0;
      end
      OPC_OP_IMM: begin
        dec.src_b_imm   = 1'b1;
        dec.alu_control = {1'b0, f3};
        if (f3 == F3_SLL) begin
          if (f7 != F7_BASE) legal = 1'b0;
        end else if (f3 == F3_SR) begin
          if (f7 == F7_ALT)
            dec.alu_control = {1'b1, f3};
          else if (f7 != F7_BASE)
            legal = 1'b0;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        dec.alu_control = ALU_ADD;
        dec.src_b_imm   = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_control = ALU_ADD;
        dec.src_a       = SRC_A_ZERO;
        dec.src_b_imm   = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_control = ALU_ADD;
        dec.src_a       = SRC_A_PC;
        dec.src_b_imm   = 1'b1;
      end
      OPC_JAL: begin
        dec.alu_control = ALU_JMP;
        dec.src_a       = SRC_A_PC;
        dec.src_b_imm   = 1'b1;
        dec.jump        = 1'b1;
      end
      OPC_JALR: begin
        dec.alu_control = ALU_JMP;
        dec.src_a       = SRC_A_RS1;
        dec.src_b_imm   = 1'b1;
        dec.jump        = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        case (f3)
          F3_BEQ:  dec.alu_control = ALU_SUB;
          F3_BNE: begin
            dec.alu_control   = ALU_SUB;
            dec.branch_negate = 1'b1;
          end
          F3_BLT:  dec.alu_control = ALU_SLT;
          F3_BGE:  dec.alu_control = ALU_SGE;
          F3_BLTU: dec.alu_control = ALU_SLTU;
          F3_BGEU: dec.alu_control = ALU_SGEU;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // An illegal entry carries no operand or control-flow information.
    if (!legal) begin
      dec             = '0;
      dec.alu_control = ALU_ERR;
      dec.illegal     = 1'b1;
    end
  end

  assign dec_imm  = dec.illegal ? '0 : imm_raw;

  assign in_ready = ~skid_valid_q & ~rst;
  assign accept   = in_valid & in_ready;
  assign load_out = ~out_valid_q | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      out_q         <= '0;
      skid_q        <= '0;
      out_imm_q     <= '0;
      skid_imm_q    <= '0;
      out_pc_q      <= '0;
      skid_pc_q     <= '0;
      illegal_count <= '0;
    end else begin
      if (flush) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (load_out) begin
        // A held skid entry is older than anything upstream, so it goes first;
        // in_ready is low while the skid is full, so no accept can collide.
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_imm_q    <= skid_imm_q;
          out_pc_q     <= skid_pc_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (accept) begin
          out_q       <= dec;
          out_imm_q   <= dec_imm;
          out_pc_q    <= in_pc;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q       <= dec;
        skid_imm_q   <= dec_imm;
        skid_pc_q    <= in_pc;
        skid_valid_q <= 1'b1;
      end

      if (accept && !flush && dec.illegal && illegal_count != '1)
        illegal_count <= illegal_count + CNT_WIDTH'(1);
    end
  end

  assign out_valid         = out_valid_q;
  assign out_alu_control   = out_q.alu_control;
  assign out_src_a         = out_q.src_a;
  assign out_src_b_imm     = out_q.src_b_imm;
  assign out_branch        = out_q.branch;
  assign out_branch_negate = out_q.branch_negate;
  assign out_jump          = out_q.jump;
  assign out_illegal       = out_q.illegal;
  assign out_imm           = out_imm_q;
  assign out_pc            = out_pc_q;

endmodule

// File: tb/tb_alu_control_unit.sv
module tb_alu_control_unit;

  localparam int WIDTH = 32;
  localparam int CNTW  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [WIDTH-1:0]  in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_alu_control;
  logic [1:0]        out_src_a;
  logic              out_src_b_imm;
  logic [WIDTH-1:0]  out_imm;
  logic              out_branch;
  logic              out_branch_negate;
  logic              out_jump;
  logic              out_illegal;
  logic [WIDTH-1:0]  out_pc;
  logic [CNTW-1:0]   illegal_count;

  always #5 clk = ~clk;

  alu_control_unit #(.WIDTH(WIDTH), .CNT_WIDTH(CNTW)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .in_pc             (in_pc),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_alu_control   (out_alu_control),
    .out_src_a         (out_src_a),
    .out_src_b_imm     (out_src_b_imm),
    .out_imm           (out_imm),
    .out_branch        (out_branch),
    .out_branch_negate (out_branch_negate),
    .out_jump          (out_jump),
    .out_illegal       (out_illegal),
    .out_pc            (out_pc),
    .illegal_count     (illegal_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  ctrl;
    logic [1:0]  src_a;
    logic        bimm;
    logic [31:0] imm;
    logic        br;
    logic        neg;
    logic        jmp;
    logic        ill;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] ctrl,
                              input logic [1:0] src_a, input logic bimm, input logic [31:0] imm,
                              input logic br, input logic neg, input logic jmp, input logic ill);
    vec_t v;
    v.instr = instr; v.ctrl = ctrl; v.src_a = src_a; v.bimm = bimm; v.imm = imm;
    v.br = br; v.neg = neg; v.jmp = jmp; v.ill = ill;
    return v;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 15) ? 15 : c + 1;
  endfunction

  // Present one entry for exactly one edge; returns at the following negedge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(32'h002081B3, 4'b0000, 2'b00, 0, 32'h0,        0, 0, 0, 0); // add
    vecs[1]  = mk(32'h402081B3, 4'b1000, 2'b00, 0, 32'h0,        0, 0, 0, 0); // sub
    vecs[2]  = mk(32'h4030D093, 4'b1101, 2'b00, 1, 32'h3,        0, 0, 0, 0); // srai 3
    vecs[3]  = mk(32'h0020D463, 4'b1010, 2'b00, 0, 32'h8,        1, 0, 0, 0); // bge +8
    vecs[4]  = mk(32'hFE209EE3, 4'b1000, 2'b00, 0, 32'hFFFFFFFC, 1, 1, 0, 0); // bne -4
    vecs[5]  = mk(32'h0020C1B3, 4'b0100, 2'b00, 0, 32'h0,        0, 0, 0, 0); // xor
    vecs[6]  = mk(32'h0020E1B3, 4'b0110, 2'b00, 0, 32'h0,        0, 0, 0, 0); // or
    vecs[7]  = mk(32'h0020F1B3, 4'b0111, 2'b00, 0, 32'h0,        0, 0, 0, 0); // and
    vecs[8]  = mk(32'h002091B3, 4'b0001, 2'b00, 0, 32'h0,        0, 0, 0, 0); // sll
    vecs[9]  = mk(32'h0020D1B3, 4'b0101, 2'b00, 0, 32'h0,        0, 0, 0, 0); // srl
    vecs[10] = mk(32'h4020D1B3, 4'b1101, 2'b00, 0, 32'h0,        0, 0, 0, 0); // sra
    vecs[11] = mk(32'h0020A1B3, 4'b0010, 2'b00, 0, 32'h0,        0, 0, 0, 0); // slt
    vecs[12] = mk(32'h0020B1B3, 4'b0011, 2'b00, 0, 32'h0,        0, 0, 0, 0); // sltu
    vecs[13] = mk(32'h4020C1B3, 4'b1111, 2'b00, 0, 32'h0,        0, 0, 0, 1); // alt funct7 on xor
    vecs[14] = mk(32'h022081B3, 4'b1111, 2'b00, 0, 32'h0,        0, 0, 0, 1); // funct7 0000001
    vecs[15] = mk(32'hFFF00093, 4'b0000, 2'b00, 1, 32'hFFFFFFFF, 0, 0, 0, 0); // addi -1
    vecs[16] = mk(32'h00509093, 4'b0001, 2'b00, 1, 32'h5,        0, 0, 0, 0); // slli 5
    vecs[17] = mk(32'h40509093, 4'b1111, 2'b00, 0, 32'h0,        0, 0, 0, 1); // slli alt funct7
    vecs[18] = mk(32'h123450B7, 4'b0000, 2'b10, 1, 32'h12345000, 0, 0, 0, 0); // lui
    vecs[19] = mk(32'h00001097, 4'b0000, 2'b01, 1, 32'h00001000, 0, 0, 0, 0); // auipc
    vecs[20] = mk(32'h008000EF, 4'b1001, 2'b01, 1, 32'h8,        0, 0, 1, 0); // jal +8
    vecs[21] = mk(32'h004100E7, 4'b1001, 2'b00, 1, 32'h4,        0, 0, 1, 0); // jalr 4(x2)
    vecs[22] = mk(32'h0020A623, 4'b0000, 2'b00, 1, 32'hC,        0, 0, 0, 0); // sw 12
    vecs[23] = mk(32'hFF812083, 4'b0000, 2'b00, 1, 32'hFFFFFFF8, 0, 0, 0, 0); // lw -8
    vecs[24] = mk(32'h00208463, 4'b1000, 2'b00, 0, 32'h8,        1, 0, 0, 0); // beq
    vecs[25] = mk(32'h0020C463, 4'b0010, 2'b00, 0, 32'h8,        1, 0, 0, 0); // blt
    vecs[26] = mk(32'h0020E463, 4'b0011, 2'b00, 0, 32'h8,        1, 0, 0, 0); // bltu
    vecs[27] = mk(32'h0020F463, 4'b1011, 2'b00, 0, 32'h8,        1, 0, 0, 0); // bgeu
    vecs[28] = mk(32'h0020A463, 4'b1111, 2'b00, 0, 32'h0,        0, 0, 0, 1); // branch f3 010
    vecs[29] = mk(32'hFFFFFFFF, 4'b1111, 2'b00, 0, 32'h0,        0, 0, 0, 1); // unknown opcode
    vecs[30] = mk(32'h0030D093, 4'b0101, 2'b00, 1, 32'h3,        0, 0, 0, 0); // srli 3

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_count", {60'd0, illegal_count}, 64'd0);
    chk("rst_outs", {out_alu_control, out_src_a, out_src_b_imm, out_imm, out_pc, out_branch,
                     out_branch_negate, out_jump, out_illegal}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Two illegal accepts, then one masked by flush.
    issue(32'hFFFFFFFF, 32'h10);
    exp_cnt = sat_inc(exp_cnt);
    chk("ill1_ctrl", {59'd0, out_alu_control, out_illegal}, {59'd0, 4'b1111, 1'b1});
    issue(32'hFFFFFFFF, 32'h14);
    exp_cnt = sat_inc(exp_cnt);
    chk("ill2_count", {60'd0, illegal_count}, 64'(exp_cnt));
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_accept_count", {60'd0, illegal_count}, 64'(exp_cnt));

    // Decode table, back-to-back with out_ready=1 (no bubbles).
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].instr, 32'h1000 + 32'(i) * 4);
      if (vecs[i].ill) exp_cnt = sat_inc(exp_cnt);
      chk($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("v%0d_ctl", i),
          {53'd0, out_alu_control, out_src_a, out_src_b_imm, out_branch, out_branch_negate, out_jump, out_illegal},
          {53'd0, vecs[i].ctrl, vecs[i].src_a, vecs[i].bimm, vecs[i].br, vecs[i].neg, vecs[i].jmp, vecs[i].ill});
      chk($sformatf("v%0d_imm", i), {32'd0, out_imm}, {32'd0, vecs[i].imm});
      chk($sformatf("v%0d_pc", i), {32'd0, out_pc}, {32'd0, 32'h1000 + 32'(i) * 4});
      chk($sformatf("v%0d_count", i), {60'd0, illegal_count}, 64'(exp_cnt));
    end
    @(negedge clk);
    chk("table_drained", {63'd0, out_valid}, 64'd0);

    // Skid: three back-to-back inputs with out_ready low.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'hA0;
    chk("sk_ready0", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_instr = 32'h402081B3; in_pc = 32'hA4;
    chk("sk_ready1", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_instr = 32'h0020C1B3; in_pc = 32'hA8;
    chk("sk_ready2_low", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("sk_hold_pc", {32'd0, out_pc}, {32'd0, 32'hA0});
    chk("sk_hold_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("sk_e1_gone_pc", {32'd0, out_pc}, {32'd0, 32'hA4});
    chk("sk_e2_ctrl", {60'd0, out_alu_control}, {60'd0, 4'b1000});
    chk("sk_ready_back", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sk_e3_pc", {32'd0, out_pc}, {32'd0, 32'hA8});
    chk("sk_e3_ctrl", {60'd0, out_alu_control}, {60'd0, 4'b0100});
    @(negedge clk);
    chk("sk_empty", {63'd0, out_valid}, 64'd0);

    // Flush with both registers full.
    out_ready = 1'b0;
    issue(32'h002081B3, 32'hB0);
    issue(32'h402081B3, 32'hB4);
    chk("fl_full_ready", {63'd0, in_ready}, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    chk("fl_stays_empty", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset with both registers full, away from any clock edge.
    issue(32'h0020A463, 32'hC0);
    issue(32'h008000EF, 32'hC4);
    chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_ready", {63'd0, in_ready}, 64'd0);
    chk("ar_count", {60'd0, illegal_count}, 64'd0);
    chk("ar_outs", {out_alu_control, out_src_a, out_src_b_imm, out_imm, out_pc, out_branch,
                    out_branch_negate, out_jump, out_illegal}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ar_skid_empty", {63'd0, in_ready}, 64'd1);
    chk("ar_no_ghost", {63'd0, out_valid}, 64'd0);

    // Counter saturation (4-bit counter in this instance).
    for (int i = 0; i < 18; i++) begin
      issue(32'hFFFFFFFF, 32'hD00 + 32'(i));
      exp_cnt = sat_inc(exp_cnt);
      if (i == 13 || i == 14 || i == 17)
        chk($sformatf("sat_%0d", i), {60'd0, illegal_count}, 64'(exp_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
